// File: rtl/datapath_step_ctrl_pkg.sv
// Shared encodings for the datapath run/step controller.
// Also used by the LED/SSD mux to decode ctrlState.
package datapath_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2,
    ST_BREAK    = 2'd3
  } ctrlState_e;

endpackage

// File: rtl/datapath_step_ctrl_btn_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for one raw push button.
// Emits a single-cycle pulse per press, no matter how long the button is held.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic syncA;
  logic syncB;
  logic prevB;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncA <= 1'b0;
      syncB <= 1'b0;
      prevB <= 1'b0;
    end else begin
      syncA <= btn;
      syncB <= syncA;
      prevB <= syncB;
    end
  end

  // Driven from flops only, so no path exists from the raw button to the pulse.
  assign pulse = syncB & ~prevB;

endmodule

// File: rtl/datapath_step_ctrl.sv
// Run/step/breakpoint sequencer producing the datapath clock-enable.
// state       | meaning
// ST_HALTED   | datapath frozen, waiting for run or step
// ST_RUNNING  | enable issued every cycle, or once per divider wrap in slow mode
// ST_STEPPING | one enable cycle, then back to halted
// ST_BREAK    | stopped before executing the instruction at bpAddr
module datapath_step_ctrl
  import datapath_step_ctrl_pkg::*;
#(
  parameter int SLOW_DIV = 4,
  parameter int CNT_W    = 32
) (
  input  logic             DatapathClk,
  input  logic             rst,
  input  logic             runReq,
  input  logic             stepReq,
  input  logic             haltReq,
  input  logic             slowMode,
  input  logic             bpEn,
  input  logic [31:0]      bpAddr,
  input  logic [31:0]      PC,
  output logic             cpuEn,
  output logic [1:0]       ctrlState,
  output logic             bpHit,
  output logic [CNT_W-1:0] cycleCount
);

  logic runPulse;
  logic stepPulse;
  logic haltPulse;

  btn_sync_edge uRunSync  (.clk(DatapathClk), .rst(rst), .btn(runReq),  .pulse(runPulse));
  btn_sync_edge uStepSync (.clk(DatapathClk), .rst(rst), .btn(stepReq), .pulse(stepPulse));
  btn_sync_edge uHaltSync (.clk(DatapathClk), .rst(rst), .btn(haltReq), .pulse(haltPulse));

  ctrlState_e          state;
  logic [SLOW_DIV-1:0] divider;
  logic                skip;
  logic                issue;
  logic                match;

  assign issue = !slowMode || (divider == '1);
  // skip lets a resume execute the instruction sitting at bpAddr exactly once.
  assign match = bpEn && (PC == bpAddr) && !skip;

  always_comb begin
    cpuEn = 1'b0;
    case (state)
      ST_RUNNING:  cpuEn = issue && !match && !haltPulse;
      ST_STEPPING: cpuEn = !haltPulse;
      default:     cpuEn = 1'b0;
    endcase
  end

  assign ctrlState = state;
  assign bpHit     = (state == ST_BREAK);

  always_ff @(posedge DatapathClk or posedge rst) begin
    if (rst) begin
      state      <= ST_HALTED;
      divider    <= '0;
      skip       <= 1'b0;
      cycleCount <= '0;
    end else begin
      if (cpuEn) begin
        skip       <= 1'b0;
        cycleCount <= cycleCount + CNT_W'(1);
      end
      case (state)
        ST_HALTED, ST_BREAK: begin
          if (haltPulse) begin
            state <= ST_HALTED;
          end else if (stepPulse) begin
            state <= ST_STEPPING;
          end else if (runPulse) begin
            state   <= ST_RUNNING;
            skip    <= 1'b1;
            divider <= '0;
          end
        end
        ST_RUNNING: begin
          // Divider keeps counting through suppressed ticks and slowMode changes.
          divider <= divider + SLOW_DIV'(1);
          if (haltPulse) begin
            state <= ST_HALTED;
          end else if (issue && match) begin
            state <= ST_BREAK;
          end
        end
        ST_STEPPING: state <= ST_HALTED;
        default:     state <= ST_HALTED;
      endcase
    end
  end

endmodule
